// File: rtl/hash_avalon_slave_if.sv
// Avalon-MM slave bus bundle for hash_avalon_slave (CPU side = master, wrapper = slave).
interface hash_avalon_slave_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                write;
    logic                read;
    logic                chipselect;
    logic [DATA_W-1:0]   readdata;

    modport master (output address, writedata, byteenable, write, read, chipselect,
                    input  readdata);
    modport slave  (input  address, writedata, byteenable, write, read, chipselect,
                    output readdata);
endinterface

// File: rtl/hash_avalon_slave.sv
// Avalon-MM front-end for hash cores: message FIFO, valid/ready streaming, digest/status regs.
// Optional feature: define HASH_AVALON_IRQ_EN to add the irq output and CTRL bit8 irq enable.
module hash_avalon_slave #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned DIGEST_WORDS = 8,
    parameter int unsigned LEN_W        = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    hash_avalon_slave_if.slave             avs,
    output logic                           core_start,
    output logic [LEN_W-1:0]               core_len,
    output logic [DATA_W-1:0]              core_data,
    output logic                           core_valid,
    input  logic                           core_ready,
    input  logic [DIGEST_WORDS*DATA_W-1:0] core_digest,
    input  logic                           core_done
`ifdef HASH_AVALON_IRQ_EN
    ,
    output logic                           irq
`endif
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_WAIT} state_t;
    state_t state_q, state_d;

    logic                           wr_c, rd_c, len_wr_c, data_wr_c, ctrl_wr_c;
    logic                           clr_done_c, clr_flags_c;
    logic                           start_c, capture_c, err_set_c, ovf_set_c;
    logic                           push_c, pop_c, empty_c, full_c;
    logic [LEN_W-1:0]               len_in_c;
    logic [CNT_W-1:0]               words_calc_c;
    logic [DATA_W-1:0]              wdata_masked_c, status_c, rd_mux_c;

    logic [DATA_W-1:0]              mem [FIFO_DEPTH];
    logic [PTR_W-1:0]               wptr_q, rptr_q;
    logic [LVL_W-1:0]               level_q;
    logic [LEN_W-1:0]               words_q;
    logic [DIGEST_WORDS*DATA_W-1:0] digest_q;
    logic                           done_q, ovf_q, err_q, irq_en_q;

    // Register decode
    assign wr_c        = avs.chipselect & avs.write;
    assign rd_c        = avs.chipselect & avs.read;
    assign len_wr_c    = wr_c && (avs.address == ADDR_W'(0));
    assign data_wr_c   = wr_c && (avs.address == ADDR_W'(1));
    assign ctrl_wr_c   = wr_c && (avs.address == ADDR_W'(4));
    assign clr_done_c  = ctrl_wr_c && (avs.writedata[0] || (avs.writedata[1:0] == 2'b00));
    assign clr_flags_c = ctrl_wr_c && avs.writedata[1];

    // Word count is ceil(len / DATA_W), computed one bit wider so the rounding add cannot wrap
    assign len_in_c     = LEN_W'(avs.writedata);
    assign words_calc_c = (CNT_W'(len_in_c) + CNT_W'(DATA_W - 1)) / CNT_W'(DATA_W);

    // FIFO status and handshakes; a full FIFO still accepts a push when a pop frees a slot
    assign empty_c    = (level_q == '0);
    assign full_c     = (level_q == LVL_W'(FIFO_DEPTH));
    assign core_valid = (state_q == ST_STREAM) && !empty_c;
    assign pop_c      = core_valid && core_ready;
    assign push_c     = data_wr_c && (!full_c || pop_c);
    assign ovf_set_c  = data_wr_c && full_c && !pop_c;
    assign core_data  = empty_c ? '0 : mem[rptr_q];

    always_comb begin
        wdata_masked_c = '0;
        for (int i = 0; i < int'(BE_W); i++) begin
            if (avs.byteenable[i]) wdata_masked_c[8*i +: 8] = avs.writedata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem[wptr_q] <= wdata_masked_c;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Message sequencing
    always_comb begin
        state_d   = state_q;
        start_c   = 1'b0;
        capture_c = 1'b0;
        err_set_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (len_wr_c) begin
                    start_c = 1'b1;
                    state_d = (words_calc_c == '0) ? ST_WAIT : ST_STREAM;
                end
            end
            ST_STREAM: begin
                err_set_c = len_wr_c;
                if ((words_q == '0) || (pop_c && (words_q == LEN_W'(1)))) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                err_set_c = len_wr_c;
                if (core_done) begin
                    capture_c = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef HASH_AVALON_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (ctrl_wr_c) irq_en_q <= avs.writedata[8];
            irq <= irq_en_q & (done_q | ovf_q | err_q);
        end
    end
`else
    assign irq_en_q = 1'b0;
`endif

    always_comb begin
        status_c       = '0;
        status_c[15:8] = 8'(level_q);
        status_c[6]    = irq_en_q;
        status_c[5]    = err_q;
        status_c[4]    = ovf_q;
        status_c[3]    = (state_q != ST_IDLE);
        status_c[2]    = full_c;
        status_c[1]    = empty_c;
        status_c[0]    = done_q;
    end

    always_comb begin
        rd_mux_c = '0;
        if (avs.address == ADDR_W'(16)) rd_mux_c = status_c;
        for (int i = 0; i < int'(DIGEST_WORDS); i++) begin
            if (avs.address == ADDR_W'(i)) rd_mux_c = digest_q[i*DATA_W +: DATA_W];
        end
    end

    // Datapath registers; set beats clear on the sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            words_q      <= '0;
            core_start   <= 1'b0;
            core_len     <= '0;
            digest_q     <= '0;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            avs.readdata <= '0;
        end else begin
            core_start <= start_c;
            if (start_c) begin
                core_len <= len_in_c;
                words_q  <= LEN_W'(words_calc_c);
            end else if (pop_c) begin
                words_q  <= words_q - LEN_W'(1);
            end
            if (push_c) wptr_q <= wptr_q + PTR_W'(1);
            if (pop_c)  rptr_q <= rptr_q + PTR_W'(1);
            if (push_c && !pop_c)      level_q <= level_q + LVL_W'(1);
            else if (pop_c && !push_c) level_q <= level_q - LVL_W'(1);
            if (capture_c) digest_q <= core_digest;
            if (capture_c)                   done_q <= 1'b1;
            else if (clr_done_c || start_c)  done_q <= 1'b0;
            if (ovf_set_c)        ovf_q <= 1'b1;
            else if (clr_flags_c) ovf_q <= 1'b0;
            if (err_set_c)        err_q <= 1'b1;
            else if (clr_flags_c) err_q <= 1'b0;
            if (rd_c) avs.readdata <= rd_mux_c;
        end
    end
endmodule
